hs_perr_mon: RTL and testbench

HS_PERR_MON -- requirements
Module: hs_perr_mon

---
 rtl/hs_perr_mon_pkg.sv | 27 ++
 rtl/hs_perr_lane.sv | 78 +++++++
 rtl/hs_perr_mon.sv | 162 ++++++++++++++++
 tb/tb_hs_perr_mon.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_perr_mon_pkg.sv
// Shared constants and types for the parity error monitor.
// Register offsets, CTRL bit positions, ID word, capture record.
package hs_perr_mon_pkg;

  localparam logic [31:0] ID_VALUE = 32'h5045_0001;

  localparam logic [7:0] OFF_ID      = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_FE_LANE = 8'h0C;
  localparam logic [7:0] OFF_FE_RE   = 8'h10;
  localparam logic [7:0] OFF_FE_IM   = 8'h14;
  localparam logic [7:0] OFF_LANE    = 8'h20;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_SNAP   = 2;
  localparam int CTRL_INJ_LO = 8;

  typedef struct packed {
    logic        valid;
    logic [2:0]  lane;
    logic [31:0] re;
    logic [31:0] im;
  } fe_t;

endpackage

// File: rtl/hs_perr_lane.sv
// One parity-protected lane: input stage, parity check,
// saturating counters with shadow copies, sticky error bit.
module hs_perr_lane
  import hs_perr_mon_pkg::*;
#(
  parameter int DATA_BITS  = 18,
  parameter int CNT_BITS   = 32,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] re,
  input  logic [DATA_BITS-1:0] im,
  input  logic                 parity,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 snap,
  output logic                 err,
  output logic                 err_pulse,
  output logic                 sticky,
  output logic [DATA_BITS-1:0] s1_re,
  output logic [DATA_BITS-1:0] s1_im,
  output logic [CNT_BITS-1:0]  err_shd,
  output logic [CNT_BITS-1:0]  smp_shd
);

  localparam logic ODD = 1'(PARITY_ODD);

  logic                s1_valid;
  logic                s1_par;
  logic [CNT_BITS-1:0] err_cnt;
  logic [CNT_BITS-1:0] smp_cnt;

  assign err = s1_valid &
    (((^s1_re) ^ (^s1_im) ^ s1_par) != ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_par    <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      err_pulse <= 1'b0;
      sticky    <= 1'b0;
      err_cnt   <= '0;
      smp_cnt   <= '0;
      err_shd   <= '0;
      smp_shd   <= '0;
    end else begin
      s1_valid  <= valid;
      s1_par    <= parity;
      s1_re     <= re;
      s1_im     <= im;
      err_pulse <= err;
      // clear beats any increment landing on the same edge
      if (clear) begin
        sticky  <= 1'b0;
        err_cnt <= '0;
        smp_cnt <= '0;
        err_shd <= '0;
        smp_shd <= '0;
      end else begin
        if (snap) begin
          err_shd <= err_cnt;
          smp_shd <= smp_cnt;
        end
        if (enable && s1_valid && smp_cnt != '1)
          smp_cnt <= smp_cnt + 1'b1;
        if (enable && err && err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
        if (err)
          sticky <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_perr_mon.sv
// Multi-lane parity error monitor with register access.
// Optional error injection: define HS_PERR_MON_INJECT_EN.
module hs_perr_mon
  import hs_perr_mon_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int DATA_BITS  = 18,
  parameter int CNT_BITS   = 32,
  parameter int PARITY_ODD = 0
) (
  input  logic                           i_sysclk,
  input  logic                           i_rst_n,
  input  logic [NUM_LANES-1:0]           i_valid,
  input  logic [NUM_LANES*DATA_BITS-1:0] i_data_re,
  input  logic [NUM_LANES*DATA_BITS-1:0] i_data_im,
  input  logic [NUM_LANES-1:0]           i_parity,
  input  logic                           i_reg_sel,
  input  logic                           i_reg_rd_wr_n,
  input  logic [7:0]                     i_reg_addr,
  input  logic [31:0]                    i_reg_wdata,
  output logic [31:0]                    o_reg_rdata,
  output logic                           o_reg_ack,
  output logic [NUM_LANES-1:0]           o_err_pulse,
  output logic                           o_err_any
);

  logic                 ctrl_wr;
  logic                 clr;
  logic                 snap;
  logic                 enable;
  logic [NUM_LANES-1:0] par_in;
  logic [NUM_LANES-1:0] lane_err;
  logic [NUM_LANES-1:0] sticky;
  logic [7:0]           inj_mask;
  logic [DATA_BITS-1:0] lane_re [NUM_LANES];
  logic [DATA_BITS-1:0] lane_im [NUM_LANES];
  logic [CNT_BITS-1:0]  err_shd [NUM_LANES];
  logic [CNT_BITS-1:0]  smp_shd [NUM_LANES];
  fe_t                  fe;
  fe_t                  fe_nxt;
  logic [31:0]          rd;
  logic                 unused_ok;

  assign ctrl_wr = i_reg_sel & ~i_reg_rd_wr_n &
                   (i_reg_addr == OFF_CTRL);
  assign clr  = ctrl_wr & i_reg_wdata[CTRL_CLR];
  assign snap = ctrl_wr & i_reg_wdata[CTRL_SNAP];
  assign unused_ok = ^i_reg_wdata;

`ifdef HS_PERR_MON_INJECT_EN
  logic [NUM_LANES-1:0] inj_q;

  // a pending inject bit is spent on the lane's next valid sample
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n)
      inj_q <= '0;
    else if (ctrl_wr)
      inj_q <= i_reg_wdata[CTRL_INJ_LO +: NUM_LANES];
    else
      inj_q <= inj_q & ~i_valid;
  end

  assign par_in   = i_parity ^ (inj_q & i_valid);
  assign inj_mask = 8'(inj_q);
`else
  assign par_in   = i_parity;
  assign inj_mask = '0;
`endif

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n)
      enable <= 1'b1;
    else if (ctrl_wr)
      enable <= i_reg_wdata[CTRL_EN];
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    hs_perr_lane #(
      .DATA_BITS  (DATA_BITS),
      .CNT_BITS   (CNT_BITS),
      .PARITY_ODD (PARITY_ODD)
    ) u_lane (
      .clk       (i_sysclk),
      .rst_n     (i_rst_n),
      .valid     (i_valid[g]),
      .re        (i_data_re[g*DATA_BITS +: DATA_BITS]),
      .im        (i_data_im[g*DATA_BITS +: DATA_BITS]),
      .parity    (par_in[g]),
      .enable    (enable),
      .clear     (clr),
      .snap      (snap),
      .err       (lane_err[g]),
      .err_pulse (o_err_pulse[g]),
      .sticky    (sticky[g]),
      .s1_re     (lane_re[g]),
      .s1_im     (lane_im[g]),
      .err_shd   (err_shd[g]),
      .smp_shd   (smp_shd[g])
    );
  end

  assign o_err_any = |sticky;

  // descending scan so the lowest erroring lane is the one kept
  always_comb begin
    fe_nxt       = '0;
    fe_nxt.valid = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_err[i]) begin
        fe_nxt.lane = 3'(i);
        fe_nxt.re   = 32'(lane_re[i]);
        fe_nxt.im   = 32'(lane_im[i]);
      end
    end
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n)
      fe <= '0;
    else if (clr)
      fe <= '0;
    else if (!fe.valid && |lane_err)
      fe <= fe_nxt;
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (i_reg_addr == OFF_ID):
        rd = ID_VALUE;
      (i_reg_addr == OFF_CTRL):
        rd = {16'h0, inj_mask, 7'h0, enable};
      (i_reg_addr == OFF_STATUS):
        rd = {fe.valid, 23'h0, 8'(sticky)};
      (i_reg_addr == OFF_FE_LANE):
        rd = 32'(fe.lane);
      (i_reg_addr == OFF_FE_RE):
        rd = fe.re;
      (i_reg_addr == OFF_FE_IM):
        rd = fe.im;
      default: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (i_reg_addr == 8'(OFF_LANE + 8*i))
            rd = 32'(err_shd[i]);
          if (i_reg_addr == 8'(OFF_LANE + 8*i + 4))
            rd = 32'(smp_shd[i]);
        end
      end
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_reg_ack   <= 1'b0;
      o_reg_rdata <= '0;
    end else begin
      o_reg_ack   <= i_reg_sel;
      o_reg_rdata <= (i_reg_sel & i_reg_rd_wr_n) ? rd : '0;
    end
  end

endmodule

// File: tb/tb_hs_perr_mon.sv
// Directed plus random bench for hs_perr_mon with a
// transaction-level reference model (2 lanes, 8-bit counters).
module tb_hs_perr_mon;

  localparam int NL   = 2;
  localparam int DB   = 18;
  localparam int CB   = 8;
  localparam int PODD = 0;
  localparam int CMAX = (1 << CB) - 1;
`ifdef HS_PERR_MON_INJECT_EN
  localparam logic [31:0] INJ_EXP = 32'd1;
`else
  localparam logic [31:0] INJ_EXP = 32'd0;
`endif

  logic          clk;
  logic          rst_n;
  logic [NL-1:0] v;
  logic [DB-1:0] re_d [NL];
  logic [DB-1:0] im_d [NL];
  logic [NL-1:0] par;
  logic          sel;
  logic          rdwn;
  logic [7:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic [NL-1:0] pulse;
  logic          any;

  int unsigned total;
  int unsigned bad;

  int          m_err [NL];
  int          m_smp [NL];
  int          s_err [NL];
  int          s_smp [NL];
  logic [NL-1:0] m_sticky;
  bit          fe_v;
  int          fe_lane;
  logic [31:0] fe_re;
  logic [31:0] fe_im;
  bit          m_en;
  logic [NL-1:0] m_inj;
  logic [NL-1:0] d1_err;
  logic [NL-1:0] d2_err;
  logic [NL-1:0] d1_val;
  logic [DB-1:0] d1_re [NL];
  logic [DB-1:0] d1_im [NL];

  hs_perr_mon #(
    .NUM_LANES  (NL),
    .DATA_BITS  (DB),
    .CNT_BITS   (CB),
    .PARITY_ODD (PODD)
  ) dut (
    .i_sysclk      (clk),
    .i_rst_n       (rst_n),
    .i_valid       (v),
    .i_data_re     ({re_d[1], re_d[0]}),
    .i_data_im     ({im_d[1], im_d[0]}),
    .i_parity      (par),
    .i_reg_sel     (sel),
    .i_reg_rd_wr_n (rdwn),
    .i_reg_addr    (addr),
    .i_reg_wdata   (wdata),
    .o_reg_rdata   (rdata),
    .o_reg_ack     (ack),
    .o_err_pulse   (pulse),
    .o_err_any     (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic gpar(input logic [DB-1:0] r,
                                input logic [DB-1:0] m);
    return 1'(($countones(r) + $countones(m) + PODD) % 2);
  endfunction

  function automatic logic perr(input logic [DB-1:0] r,
                                input logic [DB-1:0] m,
                                input logic p);
    return (($countones(r) + $countones(m) + int'(p)) % 2)
           != PODD;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : CMAX;
  endfunction

  task automatic mreset();
    for (int i = 0; i < NL; i++) begin
      m_err[i] = 0; m_smp[i] = 0;
      s_err[i] = 0; s_smp[i] = 0;
      d1_re[i] = '0; d1_im[i] = '0;
    end
    m_sticky = '0; fe_v = 0; fe_lane = 0;
    fe_re = '0; fe_im = '0; m_en = 1;
    m_inj = '0; d1_err = '0; d2_err = '0; d1_val = '0;
  endtask

  function automatic logic [31:0] mread(input logic [7:0] a);
    case (a)
      8'h00: return 32'h5045_0001;
      8'h04: return {16'h0, 6'h0, m_inj, 7'h0, m_en};
      8'h08: return {fe_v, 29'h0, m_sticky};
      8'h0C: return 32'(fe_lane);
      8'h10: return fe_re;
      8'h14: return fe_im;
      8'h20: return 32'(s_err[0]);
      8'h24: return 32'(s_smp[0]);
      8'h28: return 32'(s_err[1]);
      8'h2C: return 32'(s_smp[1]);
      default: return 32'h0;
    endcase
  endfunction

  // advance one clock; model applies what the edge does
  task automatic cycle();
    logic [NL-1:0] e_now;
    logic [NL-1:0] inj_now;
    bit cw, clr, snp;
    int ln;
    cw  = sel && !rdwn && addr == 8'h04;
    clr = cw && wdata[1];
    snp = cw && wdata[2];
`ifdef HS_PERR_MON_INJECT_EN
    inj_now = m_inj & v;
    if (cw) m_inj = wdata[8 +: NL];
    else    m_inj = m_inj & ~v;
`else
    inj_now = '0;
`endif
    for (int i = 0; i < NL; i++)
      e_now[i] = v[i] &
        (perr(re_d[i], im_d[i], par[i]) ^ inj_now[i]);
    if (clr) begin
      for (int i = 0; i < NL; i++) begin
        m_err[i] = 0; m_smp[i] = 0;
        s_err[i] = 0; s_smp[i] = 0;
      end
      m_sticky = '0; fe_v = 0; fe_lane = 0;
      fe_re = '0; fe_im = '0;
    end else begin
      if (snp)
        for (int i = 0; i < NL; i++) begin
          s_err[i] = m_err[i]; s_smp[i] = m_smp[i];
        end
      for (int i = 0; i < NL; i++) begin
        if (m_en && d1_val[i]) m_smp[i] = sat(m_smp[i]);
        if (m_en && d1_err[i]) m_err[i] = sat(m_err[i]);
      end
      m_sticky = m_sticky | d1_err;
      if (!fe_v && d1_err != '0) begin
        ln = d1_err[0] ? 0 : 1;
        fe_v = 1; fe_lane = ln;
        fe_re = 32'(d1_re[ln]); fe_im = 32'(d1_im[ln]);
      end
    end
    if (cw) m_en = wdata[0];
    d2_err = d1_err; d1_err = e_now; d1_val = v;
    for (int i = 0; i < NL; i++) begin
      d1_re[i] = re_d[i]; d1_im[i] = im_d[i];
    end
    @(posedge clk); #1;
    chk("err_pulse", 32'(pulse), 32'(d2_err));
    chk("err_any", 32'(any), 32'(|m_sticky));
  endtask

  task automatic reg_rd(input logic [7:0] a,
                        output logic [31:0] d);
    logic [31:0] exp;
    exp = mread(a);
    sel = 1; rdwn = 1; addr = a;
    cycle();
    sel = 0;
    chk($sformatf("rd_ack_%h", a), 32'(ack), 32'd1);
    chk($sformatf("rd_%h", a), rdata, exp);
    d = rdata;
  endtask

  task automatic reg_wr(input logic [7:0] a,
                        input logic [31:0] d);
    sel = 1; rdwn = 0; addr = a; wdata = d;
    cycle();
    sel = 0; rdwn = 1;
    chk($sformatf("wr_ack_%h", a), 32'(ack), 32'd1);
  endtask

  task automatic put(input int ln, input logic [DB-1:0] r,
                     input logic [DB-1:0] m, input bit flip);
    v[ln] = 1; re_d[ln] = r; im_d[ln] = m;
    par[ln] = gpar(r, m) ^ flip;
  endtask

  task automatic idle(input int n);
    v = '0;
    repeat (n) cycle();
  endtask

  logic [31:0] d;
  logic [31:0] e0;
  logic [31:0] e1;
  logic [7:0]  alist [12];

  initial begin
    total = 0; bad = 0;
    rst_n = 0; sel = 0; rdwn = 1; addr = '0; wdata = '0;
    v = '0; par = '0;
    for (int i = 0; i < NL; i++) begin
      re_d[i] = '0; im_d[i] = '0;
    end
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_any", 32'(any), 32'd0);
    rst_n = 1;
    cycle();

    reg_rd(8'h00, d);
    chk("id_const", d, 32'h5045_0001);
    cycle();
    chk("ack_one_cycle", 32'(ack), 32'd0);
    reg_rd(8'hFC, d);
    chk("unmapped_const", d, 32'd0);
    reg_rd(8'h04, d);
    chk("ctrl_rst", d, 32'd1);

    for (int i = 0; i < 100; i++) begin
      put(0, 18'($urandom), 18'($urandom), 0);
      cycle();
    end
    idle(3);
    reg_wr(8'h04, 32'h5);
    reg_rd(8'h20, d);
    chk("l0_err_const", d, 32'd0);
    reg_rd(8'h24, d);
    chk("l0_smp_const", d, 32'd100);

    for (int i = 1; i <= 10; i++) begin
      v = '0;
      if (i == 5) put(1, 18'h00ABC, 18'($urandom), 1);
      else put(1, 18'($urandom), 18'($urandom), 0);
      cycle();
      if (i == 6)
        chk("l1_pulse_const", 32'(pulse), 32'd2);
    end
    idle(3);
    reg_rd(8'h08, d);
    chk("status_const", d, 32'h8000_0002);
    reg_rd(8'h0C, d);
    chk("fe_lane_const", d, 32'd1);
    reg_rd(8'h10, d);
    chk("fe_re_const", d, 32'h0000_0ABC);
    reg_rd(8'h14, d);
    reg_wr(8'h04, 32'h5);
    reg_rd(8'h28, d);
    chk("l1_err_const", d, 32'd1);
    reg_rd(8'h2C, d);

    reg_wr(8'h04, 32'h3);
    for (int i = 0; i < 300; i++) begin
      put(0, 18'($urandom), 18'($urandom), 1);
      cycle();
    end
    idle(3);
    reg_wr(8'h04, 32'h5);
    reg_rd(8'h20, d);
    chk("sat_const", d, 32'hFF);
    reg_rd(8'h24, d);

    v = '0;
    put(0, 18'($urandom), 18'($urandom), 1);
    cycle();
    v = '0;
    reg_wr(8'h04, 32'h3);
    idle(3);
    reg_wr(8'h04, 32'h5);
    reg_rd(8'h20, d);
    chk("clr_wins_const", d, 32'd0);

    put(0, 18'($urandom), 18'($urandom), 1);
    put(1, 18'($urandom), 18'($urandom), 1);
    cycle();
    idle(3);
    chk("sim_any_const", 32'(any), 32'd1);
    reg_rd(8'h0C, d);
    chk("sim_fe_lane_const", d, 32'd0);
    reg_rd(8'h08, d);
    chk("sim_status_const", d, 32'h8000_0003);
    reg_rd(8'h10, d);

    sel = 1; rdwn = 1; addr = 8'h00;
    e0 = mread(8'h00);
    cycle();
    e1 = mread(8'h08);
    addr = 8'h08;
    chk("b2b_ack0", 32'(ack), 32'd1);
    chk("b2b_rd0", rdata, e0);
    cycle();
    sel = 0;
    chk("b2b_ack1", 32'(ack), 32'd1);
    chk("b2b_rd1", rdata, e1);

    reg_wr(8'h04, 32'h3);
    reg_wr(8'h04, 32'h101);
    for (int i = 0; i < 3; i++) begin
      put(0, 18'($urandom), 18'($urandom), 0);
      cycle();
      idle(1);
    end
    idle(3);
    reg_wr(8'h04, 32'h5);
    reg_rd(8'h20, d);
    chk("inj_cnt_const", d, INJ_EXP);
    reg_rd(8'h04, d);
    chk("inj_ctrl_const", d, 32'd1);

    reg_wr(8'h04, 32'h3);
    for (int i = 0; i < 240; i++) begin
      if (i == 80) begin
        v = '0; reg_wr(8'h04, 32'h0);
      end
      if (i == 130) begin
        v = '0; reg_wr(8'h04, 32'h1);
      end
      for (int l = 0; l < NL; l++) begin
        v[l] = 1'($urandom_range(0, 1));
        re_d[l] = 18'($urandom);
        im_d[l] = 18'($urandom);
        par[l] = gpar(re_d[l], im_d[l]) ^
                 ($urandom_range(0, 4) == 0);
      end
      cycle();
    end
    idle(3);
    reg_wr(8'h40, $urandom);
    reg_wr(8'h04, 32'h5);
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
              8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hFC};
    for (int i = 0; i < 12; i++) reg_rd(alist[i], d);

    sel = 1; rdwn = 1; addr = 8'h00;
    #2;
    rst_n = 0;
    mreset();
    @(posedge clk); #1;
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_any", 32'(any), 32'd0);
    sel = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cycle();
    reg_rd(8'h00, d);
    chk("post_rst_id", d, 32'h5045_0001);
    reg_rd(8'h08, d);
    chk("post_rst_status", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
